// File: rtl/prio_scan_pkg.sv
// Shared types and helpers for the priority scan encoder.
// Optional out_cnt port is enabled by defining PRIO_SCAN_CNT_EN.
package prio_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Index width: max(1, clog2(n)).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational highest-set-bit encoder; idx is 0 when no bit is set.
module prio_enc_n
    import prio_scan_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any_set
);

    // Ascending scan so the last hit, i.e. the highest set bit, wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = W'(i);
        end
        any_set = |vec;
    end

endmodule

// File: rtl/prio_scan_enc.sv
// Latches a request vector and emits its set-bit indices high-to-low, one per handshake.
// Defining PRIO_SCAN_CNT_EN adds out_cnt (popcount of the pending bits).
module prio_scan_enc
    import prio_scan_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_vec,
    output logic         in_ready,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         empty_pulse
`ifdef PRIO_SCAN_CNT_EN
    ,
    output logic [W:0]   out_cnt
`endif
);

    state_t         state;
    logic [N-1:0]   pend;
    logic [W-1:0]   enc_idx;
    logic           enc_any;
    logic           one_hot;

    prio_enc_n #(.N(N)) u_enc (
        .vec     (pend),
        .idx     (enc_idx),
        .any_set (enc_any)
    );

    assign one_hot   = enc_any && ((pend & (pend - N'(1))) == '0);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SCAN);
    assign out_idx   = out_valid ? enc_idx : '0;
    assign out_last  = out_valid & one_hot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pend        <= '0;
            empty_pulse <= 1'b0;
        end else begin
            empty_pulse <= 1'b0;
            // Flush beats any handshake in the same cycle, including acceptance.
            if (flush) begin
                state <= IDLE;
                pend  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            if (|in_vec) begin
                                pend  <= in_vec;
                                state <= SCAN;
                            end else begin
                                empty_pulse <= 1'b1;
                            end
                        end
                    end
                    SCAN: begin
                        if (out_ready) begin
                            pend <= pend & ~(N'(1) << enc_idx);
                            if (one_hot) state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PRIO_SCAN_CNT_EN
    // pend is all-zero in IDLE, so the count reads 0 there without gating.
    always_comb begin
        out_cnt = '0;
        for (int i = 0; i < N; i++) begin
            out_cnt = out_cnt + (W+1)'(pend[i]);
        end
    end
`endif

endmodule
